// File: rtl/irq_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter_if
// Purpose  : Bundles the interrupt source lines, claim/complete handshake and
//            meip output of the IRQ arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_arbiter_if #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = 4
);
    logic [NSRC-1:0]        irq_src;
    logic [NSRC-1:0]        src_enable;
    logic [NSRC*PRIO_W-1:0] src_prio;
    logic [PRIO_W-1:0]      threshold;
    logic                   claim_req;
    logic [ID_W-1:0]        claim_id;
    logic                   claim_valid;
    logic                   complete_req;
    logic [ID_W-1:0]        complete_id;
    logic                   meip;

    // Side that owns the interrupt lines and the trap handler strobes
    modport master (
        output irq_src, src_enable, src_prio, threshold,
        output claim_req, complete_req, complete_id,
        input  claim_id, claim_valid, meip
    );

    // Arbiter side
    modport slave (
        input  irq_src, src_enable, src_prio, threshold,
        input  claim_req, complete_req, complete_id,
        output claim_id, claim_valid, meip
    );
endinterface
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter
// Purpose  : Per-source gateways (IDLE/PENDING/INFLIGHT) with a registered
//            highest-priority winner, claim/complete handshake and meip.
// Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    irq_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_e;

    logic [ID_W-1:0] best_q;
    logic [ID_W-1:0] best_d;
    logic [ID_W-1:0] claim_id_q;
    logic            claim_valid_q;
    logic [NSRC-1:0] qual_w;

    // One gateway per source; index g serves source ID g+1
    generate
        for (genvar g = 0; g < NSRC; g++) begin : g_gw
            localparam logic [ID_W-1:0] SRC_ID = ID_W'(g + 1);

            gw_state_e         state_q;
            gw_state_e         state_d;
            logic              claim_take_w;
            logic              complete_hit_w;
            logic [PRIO_W-1:0] prio_w;

            assign prio_w         = bus.src_prio[g*PRIO_W +: PRIO_W];
            assign claim_take_w   = bus.claim_req && (best_q == SRC_ID);
            // ID 0 and IDs above NSRC can never equal SRC_ID, so they fall out here
            assign complete_hit_w = bus.complete_req && (bus.complete_id == SRC_ID);

            // A source being claimed on this edge is dropped from the next
            // arbitration so it is never handed out twice in a row.
            assign qual_w[g] = (state_q == GW_PENDING) && bus.src_enable[g] &&
                               (prio_w > bus.threshold) && !claim_take_w;

            // Gateway state register
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    state_q <= GW_IDLE;
                end else begin
                    state_q <= state_d;
                end
            end

            // Gateway transitions: latch request, hand off on claim, release on complete
            always_comb begin
                state_d = state_q;
                case (state_q)
                    GW_IDLE:     if (bus.irq_src[g]) state_d = GW_PENDING;
                    GW_PENDING:  if (claim_take_w)   state_d = GW_INFLIGHT;
                    GW_INFLIGHT: if (complete_hit_w) state_d = GW_IDLE;
                    default:     state_d = GW_IDLE;
                endcase
            end
        end
    endgenerate

    // Winner search: strict compare while scanning upward keeps the lowest ID on ties
    always_comb begin
        logic [PRIO_W-1:0] best_prio;
        best_d    = '0;
        best_prio = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (qual_w[i] && (bus.src_prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_prio = bus.src_prio[i*PRIO_W +: PRIO_W];
                best_d    = ID_W'(i + 1);
            end
        end
    end

    // Registered winner and claim response
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            best_q        <= '0;
            claim_id_q    <= '0;
            claim_valid_q <= 1'b0;
        end else begin
            best_q        <= best_d;
            claim_valid_q <= bus.claim_req;
            if (bus.claim_req) begin
                claim_id_q <= best_q;
            end
        end
    end

    assign bus.claim_id    = claim_id_q;
    assign bus.claim_valid = claim_valid_q;
    assign bus.meip        = (best_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_arbiter
// Purpose  : Directed scenarios plus randomized traffic checked against a
//            set-based reference model of the IRQ arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;
    localparam int NSRC   = 8;
    localparam int PRIO_W = 3;
    localparam int ID_W   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    irq_arbiter_if #(.NSRC(NSRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) bus ();

    irq_arbiter #(.NSRC(NSRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    // Reference model: 0 = idle, 1 = pending (latched), 2 = in service
    int m_st [1:NSRC];
    int m_best;
    int m_cid;
    int m_cv;

    function automatic int prio_of(int id);
        return int'(bus.src_prio[(id-1)*PRIO_W +: PRIO_W]);
    endfunction

    // Highest priority level first, then lowest ID within that level
    function automatic int winner(int excl);
        for (int p = (1 << PRIO_W) - 1; p > int'(bus.threshold); p--) begin
            for (int id = 1; id <= NSRC; id++) begin
                if (m_st[id] == 1 && bus.src_enable[id-1] && prio_of(id) == p && id != excl)
                    return id;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int id = 1; id <= NSRC; id++) m_st[id] = 0;
        m_best = 0;
        m_cid  = 0;
        m_cv   = 0;
    endtask

    task automatic model_edge();
        int old_st [1:NSRC];
        int nb;
        old_st = m_st;
        nb = winner(bus.claim_req ? m_best : 0);
        for (int id = 1; id <= NSRC; id++) begin
            case (old_st[id])
                0: if (bus.irq_src[id-1]) m_st[id] = 1;
                1: if (bus.claim_req && m_best == id) m_st[id] = 2;
                2: if (bus.complete_req && int'(bus.complete_id) == id) m_st[id] = 0;
                default: m_st[id] = 0;
            endcase
        end
        if (bus.claim_req) m_cid = m_best;
        m_cv   = bus.claim_req ? 1 : 0;
        m_best = nb;
    endtask

    // Advance one clock edge and step the model; returns 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        bus.irq_src      = '0;
        bus.src_enable   = '0;
        bus.src_prio     = '0;
        bus.threshold    = '0;
        bus.claim_req    = 1'b0;
        bus.complete_req = 1'b0;
        bus.complete_id  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_prio(int id, int p);
        bus.src_prio[(id-1)*PRIO_W +: PRIO_W] = PRIO_W'(p);
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        #2;
        checks++;
        if (bus.meip !== 1'b0 || bus.claim_valid !== 1'b0 || bus.claim_id !== '0) begin
            errors++;
            $display("FAIL reset_outputs: meip=%b valid=%b id=%0d, want 0/0/0",
                     bus.meip, bus.claim_valid, bus.claim_id);
        end
        bus.irq_src = '1;
        bus.src_enable = '1;
        bus.src_prio = '1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_meip: got %b want 0", bus.meip);
        end
        do_reset();
    endtask

    task automatic test_basic_claim();
        do_reset();
        bus.src_enable = '1;
        bus.threshold  = 3'd2;
        set_prio(3, 5);
        bus.irq_src[2] = 1'b1;
        tick();
        bus.irq_src = '0;
        checks++;
        if (bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL basic_meip_latency: got %b want 0", bus.meip);
        end
        tick();
        checks++;
        if (bus.meip !== 1'b1) begin
            errors++;
            $display("FAIL basic_meip_set: got %b want 1", bus.meip);
        end
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_id !== 4'd3 || bus.claim_valid !== 1'b1 || bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL basic_claim: id=%0d valid=%b meip=%b, want 3/1/0",
                     bus.claim_id, bus.claim_valid, bus.meip);
        end
        tick();
        checks++;
        if (bus.claim_valid !== 1'b0 || bus.claim_id !== 4'd3) begin
            errors++;
            $display("FAIL basic_hold: valid=%b id=%0d, want 0/3", bus.claim_valid, bus.claim_id);
        end
    endtask

    task automatic test_priority_order();
        int exp_ids [4] = '{5, 2, 6, 0};
        do_reset();
        bus.src_enable = '1;
        set_prio(2, 4);
        set_prio(6, 4);
        set_prio(5, 6);
        bus.irq_src = 8'b0011_0010;
        tick();
        bus.irq_src = '0;
        tick();
        bus.claim_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (int'(bus.claim_id) != exp_ids[k] || bus.claim_valid !== 1'b1) begin
                errors++;
                $display("FAIL prio_claim%0d: id=%0d valid=%b, want %0d/1",
                         k, bus.claim_id, bus.claim_valid, exp_ids[k]);
            end
        end
        bus.claim_req = 1'b0;
    endtask

    task automatic test_threshold();
        do_reset();
        bus.src_enable = '1;
        bus.threshold  = 3'd3;
        set_prio(4, 3);
        bus.irq_src[3] = 1'b1;
        tick();
        bus.irq_src = '0;
        tick();
        tick();
        checks++;
        if (bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL thr_equal_blocks: got %b want 0", bus.meip);
        end
        bus.threshold = 3'd2;
        #1;
        checks++;
        if (bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL thr_before_edge: got %b want 0", bus.meip);
        end
        tick();
        checks++;
        if (bus.meip !== 1'b1) begin
            errors++;
            $display("FAIL thr_lowered: got %b want 1", bus.meip);
        end
    endtask

    task automatic test_complete();
        do_reset();
        bus.src_enable = '1;
        set_prio(1, 7);
        bus.irq_src[0] = 1'b1;
        tick();
        tick();
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_id !== 4'd1 || bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL cpl_claim: id=%0d meip=%b, want 1/0", bus.claim_id, bus.meip);
        end
        tick();
        tick();
        checks++;
        if (bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL cpl_no_repend: got %b want 0", bus.meip);
        end
        bus.complete_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.complete_id = (k == 0) ? 4'd7 : (k == 1) ? 4'd0 : 4'd9;
            tick();
        end
        bus.complete_req = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL cpl_bad_ids_ignored: got %b want 0", bus.meip);
        end
        bus.complete_req = 1'b1;
        bus.complete_id  = 4'd1;
        tick();
        bus.complete_req = 1'b0;
        tick();
        checks++;
        if (bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL cpl_repend_latency: got %b want 0", bus.meip);
        end
        tick();
        checks++;
        if (bus.meip !== 1'b1) begin
            errors++;
            $display("FAIL cpl_repend: got %b want 1", bus.meip);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.src_enable = '1;
        set_prio(2, 1);
        bus.irq_src[1] = 1'b1;
        tick();
        bus.irq_src = '0;
        tick();
        bus.claim_req = 1'b1;
        tick();
        checks++;
        if (bus.claim_id !== 4'd2 || bus.claim_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: id=%0d valid=%b, want 2/1", bus.claim_id, bus.claim_valid);
        end
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_id !== 4'd0 || bus.claim_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: id=%0d valid=%b, want 0/1", bus.claim_id, bus.claim_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.src_enable = '1;
        set_prio(3, 5);
        set_prio(6, 2);
        bus.irq_src = 8'b0010_0100;
        tick();
        bus.irq_src = '0;
        tick();
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_id !== 4'd3 || bus.meip !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup: id=%0d meip=%b, want 3/1", bus.claim_id, bus.meip);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.meip !== 1'b0 || bus.claim_id !== 4'd0 || bus.claim_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: meip=%b id=%0d valid=%b, want 0/0/0",
                     bus.meip, bus.claim_id, bus.claim_valid);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (bus.meip !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: got %b want 0", bus.meip);
        end
    endtask

    task automatic test_random();
        int inflight [$];
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 20 == 0) bus.src_enable = NSRC'($urandom) | NSRC'($urandom);
            if (c % 25 == 0) bus.src_prio   = (NSRC*PRIO_W)'($urandom);
            if (c % 30 == 0) bus.threshold  = PRIO_W'($urandom_range(0, 3));
            bus.irq_src   = NSRC'($urandom) & NSRC'($urandom);
            bus.claim_req = ($urandom_range(0, 2) == 0);
            bus.complete_req = ($urandom_range(0, 2) == 0);
            inflight.delete();
            for (int id = 1; id <= NSRC; id++) if (m_st[id] == 2) inflight.push_back(id);
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1)
                bus.complete_id = ID_W'(inflight[$urandom_range(0, inflight.size() - 1)]);
            else
                bus.complete_id = ID_W'($urandom_range(0, 15));
            tick();
            checks++;
            if (bus.meip !== (m_best != 0) || int'(bus.claim_id) != m_cid ||
                int'(bus.claim_valid) != m_cv) begin
                errors++;
                $display("FAIL rand_cycle%0d: meip=%b id=%0d valid=%b, want %0d/%0d/%0d",
                         c, bus.meip, bus.claim_id, bus.claim_valid, (m_best != 0), m_cid, m_cv);
            end
        end
        bus.claim_req    = 1'b0;
        bus.complete_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_claim();
        test_priority_order();
        test_threshold();
        test_complete();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
